// File: rtl/csd_mult_seq.sv
// Sequential signed multiplier: the multiplier is recoded to non-adjacent CSD form and accumulated one digit per cycle.
// Optional build macro CSD_ZERO_SKIP_EN: COMPUTE visits only the non-zero CSD digits.
module csd_mult_seq #(
  parameter int W  = 7,
  parameter int RW = 2 * W + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  input_y,
  input  logic [W-1:0]  input_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] result
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [1:0] {IDLE, RECODE, COMPUTE, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  pos_q, pos_d;
  logic [W-1:0]  neg_q, neg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] result_q, result_d;
  logic          out_valid_q, out_valid_d;

  // NAF digits from 3y vs y: a +1 digit sits where 3y has a bit y lacks, a -1 digit the reverse.
  logic signed [W+1:0] y_ext, y_x3;
  logic [W+1:0]        y_diff;
  logic [W-1:0]        rec_pos, rec_neg;
  logic                unused_diff_bits;

  assign y_ext            = {{2{y_q[W-1]}}, y_q};
  assign y_x3             = y_ext + (y_ext <<< 1);
  assign y_diff           = y_x3 ^ y_ext;
  assign rec_pos          = y_diff[W:1] & y_x3[W:1];
  assign rec_neg          = y_diff[W:1] & y_ext[W:1];
  assign unused_diff_bits = y_diff[W+1] ^ y_diff[0];

  logic [RW-1:0] x_ext, term;
  assign x_ext = {{(RW - W){x_q[W-1]}}, x_q};
  assign term  = x_ext << idx_q;

`ifdef CSD_ZERO_SKIP_EN
  function automatic logic [IW-1:0] lowest_digit(input logic [W-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (m[i]) r = IW'(i);
    end
    return r;
  endfunction

  logic [W-1:0] remain;
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pos_d       = pos_q;
    neg_d       = neg_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
`ifdef CSD_ZERO_SKIP_EN
    remain      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d      = input_x;
          y_d      = input_y;
          acc_d    = '0;
          result_d = '0;
          idx_d    = '0;
          pos_d    = '0;
          neg_d    = '0;
          state_d  = RECODE;
        end
      end
      RECODE: begin
        pos_d = rec_pos;
        neg_d = rec_neg;
`ifdef CSD_ZERO_SKIP_EN
        if ((rec_pos | rec_neg) == '0) begin
          result_d    = acc_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d   = lowest_digit(rec_pos | rec_neg);
          state_d = COMPUTE;
        end
`else
        idx_d   = '0;
        state_d = COMPUTE;
`endif
      end
      COMPUTE: begin
        if (pos_q[idx_q]) begin
          acc_d = acc_q + term;
        end else if (neg_q[idx_q]) begin
          acc_d = acc_q - term;
        end
`ifdef CSD_ZERO_SKIP_EN
        pos_d[idx_q] = 1'b0;
        neg_d[idx_q] = 1'b0;
        remain       = pos_d | neg_d;
        if (remain == '0) begin
          result_d    = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = lowest_digit(remain);
        end
`else
        if (idx_q == LAST_IDX) begin
          result_d    = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      pos_q       <= '0;
      neg_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_csd_mult_seq.sv
// Scoreboard bench for csd_mult_seq: product and completion edge predicted from plain arithmetic and an iterative NAF digit count.
module tb_csd_mult_seq;
  localparam int W  = 7;
  localparam int RW = 2 * W + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  input_x, input_y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] result;

  csd_mult_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_y(input_y), .input_x(input_x), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    longint res;
    int     edge_n;
    int     x;
    int     y;
  } exp_t;
  exp_t sb[$];

  bit stall = 1'b1;

  always @(negedge clk) out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Non-zero digits of the non-adjacent form, found by repeated halving.
  function automatic int naf_count(input int v);
    int n = 0;
    while (v != 0) begin
      if ((v & 1) != 0) begin
        if ((v & 3) == 1) v = v - 1;
        else v = v + 1;
        n++;
      end
      v = v / 2;
    end
    return n;
  endfunction

  function automatic int exp_lat(input int y);
`ifdef CSD_ZERO_SKIP_EN
    return 1 + naf_count(y);
`else
    return 1 + W + 0 * naf_count(y);
`endif
  endfunction

  task automatic send(input int x, input int y);
    int t = 0;
    exp_t e;
    @(negedge clk);
    input_x  = W'(x);
    input_y  = W'(y);
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept x=%0d y=%0d", x, y);
      in_valid = 1'b0;
      return;
    end
    e.res    = longint'(x) * longint'(y);
    e.edge_n = cyc + 1 + exp_lat(y);
    e.x      = x;
    e.y      = y;
    sb.push_back(e);
    $display("ISSUE x=%0d y=%0d expect=%0d edge=%0d", x, y, e.res, e.edge_n);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || out_valid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0 pending", sb.size());
    end
  endtask

  logic [RW-1:0] held;
  bit ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0d required=no_output", $signed(result));
        end else begin
          e = sb.pop_front();
          $display("RESULT x=%0d y=%0d got=%0d want=%0d edge=%0d want_edge=%0d",
                   e.x, e.y, $signed(result), e.res, cyc, e.edge_n);
          chk("result", longint'($signed(result)), e.res);
          chk("valid_edge", cyc, e.edge_n);
        end
        held = result;
      end else if (out_valid) begin
        chk("hold_stable", longint'(result), longint'(held));
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    int t;
    longint ex;
    reset    = 1'b1;
    in_valid = 1'b1;
    input_x  = W'(42);
    input_y  = W'(21);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", longint'(result), 0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_result", longint'(result), 0);
    stall = 1'b0;

    send(63, 63);
    send(63, -61);
    send(-1, -64);
    send(-64, -64);
    send(42, 0);
    send(0, -64);
    send(-64, 63);
    drain();

    // Hold in DONE while new operands are offered.
    stall = 1'b1;
    send(-37, 55);
    ex = -37 * 55;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reach_done", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      input_x  = W'(11);
      input_y  = W'(-5);
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", longint'($signed(result)), ex);
    end
    stall = 1'b0;
    send(11, -5);
    drain();

    // Abort mid-COMPUTE.
    send(21, 42);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", longint'(result), 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_post_result", longint'(result), 0);
    chk("abort_post_in_ready", in_ready, 1);
    send(-50, 33);
    drain();

    repeat (40) begin
      send(int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 127)) - 64);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csd_mult_seq.md
CSD_MULT_SEQ -- requirements
Module: csd_mult_seq

Interface
REQ-001 Parameter W, default 7, operand width in bits; legal range 4..16.
REQ-002 Parameter RW, default 2*W+1, result width; not overridden by users.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair present on input_x/input_y.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 input_y  input  W  multiplier, two's complement; CSD-recoded internally.
REQ-008 input_x  input  W  multiplicand, two's complement.
REQ-009 out_valid  output  1  result holds a finished product.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  RW  signed product input_x*input_y, sign-extended to RW bits.

Function
REQ-012 States: IDLE, RECODE, COMPUTE, DONE; encoding free.
REQ-013 in_ready = 1 only in IDLE with reset low; accept when in_valid and in_ready are both high at an edge (edge k).
REQ-014 On accept: both operands registered, accumulator and result cleared, digit index cleared, state -> RECODE.
REQ-015 RECODE, one cycle: registered input_y converted to W-digit non-adjacent CSD form (digits -1/0/+1, no two adjacent non-zero); state -> COMPUTE.
REQ-016 COMPUTE: one digit i per cycle, LSB first; accumulator += d_i * (sign-extended x << i), all arithmetic at RW bits, no overflow possible.
REQ-017 After the last digit is processed, the accumulator is copied to result, out_valid = 1, state -> DONE.
REQ-018 DONE: result and out_valid held stable while out_ready is low; in_valid ignored.
REQ-019 DONE with out_ready high at an edge: out_valid -> 0, state -> IDLE; result keeps its last value.
REQ-020 Boundary: input_y = 0 yields result 0; input_y = -2^(W-1) and input_x = -2^(W-1) yields +2^(2W-2) exactly.
REQ-021 Operand changes while not in IDLE have no effect on the operation in flight.

Reset
REQ-022 reset high, at any time including mid-COMPUTE: state -> IDLE, out_valid = 0, in_ready = 0, result = 0, accumulator/digits/index = 0; the in-flight operation is discarded.
REQ-023 First accept possible at the first rising edge after reset deasserts.

Configuration
REQ-024 Macro CSD_ZERO_SKIP_EN. Defined: COMPUTE visits only non-zero digits. Count N = non-zero digits. out_valid rises at edge k+1+N. N = 0 goes RECODE -> DONE directly, with out_valid at edge k+1.
REQ-025 Undefined: all W digits visited, fixed latency, out_valid rises at edge k+1+W. Result values are identical in both builds.

Verification (W=7)
REQ-026 Reset high with operands driven, then released: result = 0, out_valid = 0, in_ready = 1 on the first cycle after release.
REQ-027 x = 63, y = 63: result = 3969 (15'h0F81). N = 2. out_valid at k+3 with skip, k+8 without.
REQ-028 x = 63, y = -61: result = -3843 (15'h70FD). N = 3. out_valid at k+4 with skip, k+8 without.
REQ-029 x = -1, y = -64: result = 64. x = -64, y = -64: result = 4096. x = 42, y = 0: result = 0, out_valid at k+1 with skip.
REQ-030 out_ready held low 5 cycles in DONE, with in_valid high and new operands driven: result stable, in_ready = 0. out_ready high -> IDLE, then the next pair is accepted.
REQ-031 Reset pulse during COMPUTE: out_valid never asserts for the aborted pair, result = 0. The next operation completes correctly.
